cuasi_alu_arbiter: RTL and testbench
====================================

// Module: cuasi_alu_arbiter
// PURPOSE
//  Shares one combinational cuasi ALU (ports a, b, sel -> c) between two requesters.
//  - Round-robin arbitration.
//  - Operands are registered and driven to the ALU.
//  - The ALU result is captured after ALU_LAT cycles.
//  - Result is returned on a valid/ready response channel, tagged with requester id.
//  Sits between the requesting sequencers and the cuasi ALU instance.
// PARAMETERS
//  WIDTH    4  operand/result width (a, b, c)
//  SEL_W    4  ALU opcode width (0 = add, 1 = AND; other codes passed through unchanged)
//  ALU_LAT  1  cycles to wait after operand launch before sampling alu_c; legal 1..15
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  req0_valid  in   1        requester 0 has an operation
//  req0_ready  out  1        requester 0 operation accepted this cycle
//  req0_a      in   WIDTH    requester 0 operand A
//  req0_b      in   WIDTH    requester 0 operand B
//  req0_sel    in   SEL_W    requester 0 opcode
//  req1_valid  in   1        requester 1 has an operation
//  req1_ready  out  1        requester 1 operation accepted this cycle
//  req1_a      in   WIDTH    requester 1 operand A
//  req1_b      in   WIDTH    requester 1 operand B
//  req1_sel    in   SEL_W    requester 1 opcode
//  rsp_valid   out  1        response available
//  rsp_ready   in   1        consumer accepts response
//  rsp_id      out  1        requester that owns the response
//  rsp_c       out  WIDTH    ALU result
//  alu_a       out  WIDTH    registered operand A to ALU .a
//  alu_b       out  WIDTH    registered operand B to ALU .b
//  alu_sel     out  SEL_W    registered opcode to ALU .sel
//  alu_c       in   WIDTH    ALU result .c
// BEHAVIOUR
//  Reset (sync, rst=1 at edge):
//  - state=IDLE, last_grant=1 (req0 wins first tie), wait counter=0.
//  - Outputs: rsp_valid=0, rsp_id=0, rsp_c=0, alu_a=0, alu_b=0, alu_sel=0.
//  - Outputs: req0_ready=0, req1_ready=0.
//  - Reset mid-operation aborts the operation; the in-flight result is discarded, never presented.
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//  - IDLE: grant = only valid requester; if both are valid, grant = !last_grant.
//    - reqN_ready=1 combinationally for the granted requester only, and only in IDLE.
//    - On handshake: alu_a/b/sel <= reqN operands, id <= N, cnt <= ALU_LAT, -> WAIT.
//    - No valid requester: stay in IDLE.
//  - WAIT: cnt decrements each cycle.
//    - At cnt==1: rsp_c <= alu_c, rsp_id <= id, rsp_valid <= 1, last_grant <= id, -> RESP.
//  - RESP: rsp_valid=1; rsp_c and rsp_id held stable until rsp_valid & rsp_ready.
//    - On handshake: rsp_valid <= 0, -> IDLE.
//  Timing and hold rules:
//  - Latency: accept edge E0; rsp_valid is high from edge E0+ALU_LAT onward.
//  - Minimum issue interval is ALU_LAT+2 cycles (one op in flight).
//  - alu_a/b/sel hold the last operation until the next acceptance; not cleared on completion.
//  - Both ready outputs are 0 in WAIT and RESP; requesters hold valid and operands (no drop).
//  Arithmetic:
//  - Performed by the ALU; result is WIDTH bits, carry/overflow discarded.
//  - The block does not decode sel.
// TESTING
//  1. req0 a=8 b=6 sel=0 -> rsp_c=14, rsp_id=0, rsp_valid ALU_LAT cycles after accept.
//  2. req0 a=8 b=6 sel=1 -> rsp_c=0; then a=10 b=2 sel=0 -> rsp_c=12.
//  3. Same cycle, from reset:
//     - req0 a=3 b=2 sel=0 and req1 a=1 b=1 sel=1 -> req0 served first (c=5, id=0);
//       then req1 (c=1, id=1).
//  4. Both held valid for 4 operations -> grants alternate 0,1,0,1; ready never high in WAIT/RESP.
//  5. rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_c/rsp_id stable; no ready asserted.
//     - a=15 b=1 sel=0 -> c=0 (wrap).
//  6. rst pulsed during WAIT -> next cycle all outputs 0, no rsp_valid.
//     - Next request is served normally with req0 priority.

Source files
------------

// File: rtl/cuasi_alu_arbiter.sv
// -----------------------------------------------------------------------------
// cuasi_alu_arbiter
//
// Purpose:
//   Shares a single combinational cuasi ALU between two requesters. A
//   round-robin arbiter picks one requester while the block is idle. The
//   block then registers that requester's operands onto the ALU ports, waits
//   ALU_LAT cycles, captures the ALU result and presents it on a valid/ready
//   response channel tagged with the requester id. Only one operation is in
//   flight at a time.
//
// Parameters:
//   WIDTH    operand/result width of the ALU (a, b, c)
//   SEL_W    ALU opcode width (the opcode is forwarded, never decoded here)
//   ALU_LAT  cycles between operand launch and sampling of i_alu_c (1..15)
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst           synchronous, active-high reset
//   i_req0_valid    requester 0 has an operation
//   o_req0_ready    requester 0 operation accepted this cycle (comb, IDLE only)
//   i_req0_a/b/sel  requester 0 operands and opcode
//   i_req1_valid    requester 1 has an operation
//   o_req1_ready    requester 1 operation accepted this cycle (comb, IDLE only)
//   i_req1_a/b/sel  requester 1 operands and opcode
//   o_rsp_valid     response available (registered)
//   i_rsp_ready     consumer accepts the response
//   o_rsp_id        requester that owns the response (registered)
//   o_rsp_c         captured ALU result (registered)
//   o_alu_a/b/sel   registered operands/opcode driven to the ALU
//   i_alu_c         ALU result
// -----------------------------------------------------------------------------
module cuasi_alu_arbiter #(
   parameter int WIDTH   = 4,
   parameter int SEL_W   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req0_valid,
   output logic               o_req0_ready,
   input  logic [WIDTH-1:0]   i_req0_a,
   input  logic [WIDTH-1:0]   i_req0_b,
   input  logic [SEL_W-1:0]   i_req0_sel,
   input  logic               i_req1_valid,
   output logic               o_req1_ready,
   input  logic [WIDTH-1:0]   i_req1_a,
   input  logic [WIDTH-1:0]   i_req1_b,
   input  logic [SEL_W-1:0]   i_req1_sel,
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic               o_rsp_id,
   output logic [WIDTH-1:0]   o_rsp_c,
   output logic [WIDTH-1:0]   o_alu_a,
   output logic [WIDTH-1:0]   o_alu_b,
   output logic [SEL_W-1:0]   o_alu_sel,
   input  logic [WIDTH-1:0]   i_alu_c
);

   // Wait counter is 4 bits wide, which covers the legal ALU_LAT range 1..15.
   localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic                r_last_grant;
   logic [3:0]          r_cnt;
   logic                r_id;
   logic                r_rsp_valid;
   logic                r_rsp_id;
   logic [WIDTH-1:0]    r_rsp_c;
   logic [WIDTH-1:0]    r_alu_a;
   logic [WIDTH-1:0]    r_alu_b;
   logic [SEL_W-1:0]    r_alu_sel;

   logic                w_grant;
   logic                w_any_valid;
   logic                w_req0_ready;
   logic                w_req1_ready;
   logic                w_accept;
   logic                w_cnt_done;
   logic                w_rsp_hs;

   assign w_any_valid = i_req0_valid | i_req1_valid;
   assign w_accept    = w_req0_ready | w_req1_ready;
   assign w_rsp_hs    = r_rsp_valid & i_rsp_ready;

   // A counter at 0 can only come from a corrupted state; treat it as done
   // rather than wrapping to 15 and stalling for a full count.
   assign w_cnt_done  = (r_cnt <= 4'd1);

   // Round-robin grant: a lone requester wins outright, a tie goes to the
   // requester that was not served last.
   always_comb begin
      w_grant = 1'b0;
      if (i_req0_valid && i_req1_valid) begin
         w_grant = ~r_last_grant;
      end else if (i_req1_valid) begin
         w_grant = 1'b1;
      end else begin
         w_grant = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic for IDLE -> WAIT -> RESP -> IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_WAIT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (w_cnt_done) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (w_rsp_hs) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Ready outputs: only the granted requester, only in IDLE, never while
   // reset is asserted.
   always_comb begin
      w_req0_ready = 1'b0;
      w_req1_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!i_rst && w_any_valid) begin
               w_req0_ready = ~w_grant;
               w_req1_ready = w_grant;
            end else begin
               w_req0_ready = 1'b0;
               w_req1_ready = 1'b0;
            end
         end
         default: begin
            w_req0_ready = 1'b0;
            w_req1_ready = 1'b0;
         end
      endcase
   end

   // Operand launch: the accepted requester's operands go to the ALU and stay
   // there until the next acceptance (not cleared on completion).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_alu_a   <= {WIDTH{1'b0}};
         r_alu_b   <= {WIDTH{1'b0}};
         r_alu_sel <= {SEL_W{1'b0}};
         r_id      <= 1'b0;
      end else if (w_accept) begin
         if (w_grant) begin
            r_alu_a   <= i_req1_a;
            r_alu_b   <= i_req1_b;
            r_alu_sel <= i_req1_sel;
         end else begin
            r_alu_a   <= i_req0_a;
            r_alu_b   <= i_req0_b;
            r_alu_sel <= i_req0_sel;
         end
         r_id <= w_grant;
      end else begin
         r_alu_a   <= r_alu_a;
         r_alu_b   <= r_alu_b;
         r_alu_sel <= r_alu_sel;
         r_id      <= r_id;
      end
   end

   // Latency counter: loaded on acceptance, counts down while waiting.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= 4'd0;
      end else if (w_accept) begin
         r_cnt <= LAT_LOAD;
      end else if (r_state == ST_WAIT && !w_cnt_done) begin
         r_cnt <= r_cnt - 4'd1;
      end else if (r_state == ST_WAIT) begin
         r_cnt <= 4'd0;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Response capture and hold: result and id are frozen while rsp_valid is
   // high; the round-robin pointer moves only once the result is captured.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_c      <= {WIDTH{1'b0}};
         r_last_grant <= 1'b1;
      end else if (r_state == ST_WAIT && w_cnt_done) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_id     <= r_id;
         r_rsp_c      <= i_alu_c;
         r_last_grant <= r_id;
      end else if (r_state == ST_RESP && w_rsp_hs) begin
         r_rsp_valid  <= 1'b0;
      end else begin
         r_rsp_valid  <= r_rsp_valid;
         r_rsp_id     <= r_rsp_id;
         r_rsp_c      <= r_rsp_c;
         r_last_grant <= r_last_grant;
      end
   end

   assign o_req0_ready = w_req0_ready;
   assign o_req1_ready = w_req1_ready;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_id     = r_rsp_id;
   assign o_rsp_c      = r_rsp_c;
   assign o_alu_a      = r_alu_a;
   assign o_alu_b      = r_alu_b;
   assign o_alu_sel    = r_alu_sel;

endmodule

// File: tb/tb_cuasi_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cuasi_alu_arbiter
//
// Purpose:
//   Self-checking bench for cuasi_alu_arbiter. Provides the external ALU,
//   drives two requesters that hold valid until accepted, and compares every
//   cycle against a transaction-level model (busy flag, accept time, expected
//   result, round-robin pointer).
// -----------------------------------------------------------------------------
module tb_cuasi_alu_arbiter;

   localparam int WIDTH   = 4;
   localparam int SEL_W   = 4;
   localparam int ALU_LAT = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0_valid = 1'b0;
   logic             req0_ready;
   logic [3:0]       req0_a = 4'd0;
   logic [3:0]       req0_b = 4'd0;
   logic [3:0]       req0_sel = 4'd0;
   logic             req1_valid = 1'b0;
   logic             req1_ready;
   logic [3:0]       req1_a = 4'd0;
   logic [3:0]       req1_b = 4'd0;
   logic [3:0]       req1_sel = 4'd0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic             rsp_id;
   logic [3:0]       rsp_c;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [3:0]       alu_sel;
   logic [3:0]       alu_c;

   int passed = 0;
   int total  = 0;

   // Environment ALU: 0 = add, 1 = AND, anything else passes A through.
   function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s);
      case (s)
         4'd0:    return a + b;
         4'd1:    return a & b;
         default: return a;
      endcase
   endfunction

   assign alu_c = ref_alu(alu_a, alu_b, alu_sel);

   cuasi_alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W), .ALU_LAT(ALU_LAT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
      .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_sel(req0_sel),
      .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
      .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_sel(req1_sel),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_id(rsp_id), .o_rsp_c(rsp_c),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
      .i_alu_c(alu_c)
   );

   always #5 clk = ~clk;

   // Model state
   int         cyc = 0;
   bit         busy = 1'b0;
   int         acc_cyc = 0;
   bit         lg = 1'b1;
   logic [3:0] exp_c = 4'd0;
   bit         exp_id = 1'b0;
   logic [3:0] m_a = 4'd0, m_b = 4'd0, m_sel = 4'd0;
   // Requester state: pending op held until accepted
   bit         p0 = 1'b0, p1 = 1'b0;
   logic [3:0] a0, b0, s0, a1, b1, s1;
   bit         rr = 1'b1;
   bit         rand_mode = 1'b0;
   int         refill = 0;
   int         grants[$];
   int         obs_c[$];
   int         obs_id[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
   endtask

   task automatic new_op(input bit who);
      if (who) begin
         p1 = 1'b1; a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
         s1 = 4'($urandom_range(0, 3));
      end else begin
         p0 = 1'b1; a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
         s0 = 4'($urandom_range(0, 3));
      end
   endtask

   task automatic set_op(input bit who, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] s);
      if (who) begin p1 = 1'b1; a1 = a; b1 = b; s1 = s; end
      else     begin p0 = 1'b1; a0 = a; b0 = b; s0 = s; end
   endtask

   // One clock cycle: drive at negedge, check, then advance the model to the
   // state it must be in after the following rising edge.
   task automatic cycle();
      bit e0, e1, ev, g;
      @(negedge clk);
      if (rand_mode) begin
         if (!p0 && $urandom_range(0, 1) == 0) new_op(1'b0);
         if (!p1 && $urandom_range(0, 1) == 0) new_op(1'b1);
         rr = ($urandom_range(0, 3) != 0);
      end
      rst = 1'b0;
      req0_valid = p0; req0_a = a0; req0_b = b0; req0_sel = s0;
      req1_valid = p1; req1_a = a1; req1_b = b1; req1_sel = s1;
      rsp_ready = rr;
      #1;
      e0 = 1'b0; e1 = 1'b0;
      g = (p0 && p1) ? !lg : p1;
      if (!busy && (p0 || p1)) begin
         if (g) e1 = 1'b1; else e0 = 1'b1;
      end
      ev = busy && (cyc >= acc_cyc + ALU_LAT);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
         chk("rsp_c", rsp_c, exp_c);
         chk("rsp_id", rsp_id, exp_id);
      end
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_sel", alu_sel, m_sel);
      if (ev && rr) begin
         busy = 1'b0;
         obs_c.push_back(int'(rsp_c));
         obs_id.push_back(int'(rsp_id));
      end
      if (e0 || e1) begin
         busy = 1'b1; acc_cyc = cyc + 1; lg = g; exp_id = g; grants.push_back(int'(g));
         if (g) begin m_a = a1; m_b = b1; m_sel = s1; p1 = 1'b0; end
         else   begin m_a = a0; m_b = b0; m_sel = s0; p0 = 1'b0; end
         exp_c = ref_alu(m_a, m_b, m_sel);
         if (refill > 0) begin new_op(g); refill--; end
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_c", rsp_c, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      busy = 1'b0; lg = 1'b1; m_a = 4'd0; m_b = 4'd0; m_sel = 4'd0;
      p0 = 1'b0; p1 = 1'b0; refill = 0; rr = 1'b1;
      cyc += 2;
   endtask

   task automatic run_idle(input int budget);
      int n = 0;
      while ((busy || p0 || p1) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_timeout", (busy || p0 || p1), 0);
   endtask

   task automatic clear_logs();
      grants.delete(); obs_c.delete(); obs_id.delete();
   endtask

   task automatic check_obs(input string tag, input int idx, input int c, input int id);
      if (idx < obs_c.size()) begin
         chk(tag, obs_c[idx], c);
         chk(tag, obs_id[idx], id);
      end else begin
         chk(tag, obs_c.size(), idx + 1);
      end
   endtask

   task automatic check_grant(input string tag, input int idx, input int id);
      if (idx < grants.size()) chk(tag, grants[idx], id);
      else chk(tag, grants.size(), idx + 1);
   endtask

   initial begin
      a0 = 4'd0; b0 = 4'd0; s0 = 4'd0; a1 = 4'd0; b1 = 4'd0; s1 = 4'd0;
      do_reset();

      // 1: add
      clear_logs();
      set_op(1'b0, 4'd8, 4'd6, 4'd0);
      run_idle(50);
      check_obs("t1_add", 0, 14, 0);

      // 2: AND then add
      clear_logs();
      set_op(1'b0, 4'd8, 4'd6, 4'd1);
      run_idle(50);
      set_op(1'b0, 4'd10, 4'd2, 4'd0);
      run_idle(50);
      check_obs("t2_and", 0, 0, 0);
      check_obs("t2_add", 1, 12, 0);

      // 3: simultaneous requests right after reset, req0 first
      do_reset();
      clear_logs();
      set_op(1'b0, 4'd3, 4'd2, 4'd0);
      set_op(1'b1, 4'd1, 4'd1, 4'd1);
      run_idle(50);
      check_obs("t3_first", 0, 5, 0);
      check_obs("t3_second", 1, 1, 1);

      // 4: both held valid for four operations, grants alternate
      clear_logs();
      new_op(1'b0); new_op(1'b1); refill = 2;
      run_idle(100);
      check_grant("t4_g0", 0, 0);
      check_grant("t4_g1", 1, 1);
      check_grant("t4_g2", 2, 0);
      check_grant("t4_g3", 3, 1);

      // 5: response back-pressured 5 cycles, wrapping add
      clear_logs();
      set_op(1'b0, 4'd15, 4'd1, 4'd0);
      rr = 1'b0;
      for (int i = 0; i < ALU_LAT + 6; i++) cycle();
      chk("t5_held", obs_c.size(), 0);
      rr = 1'b1;
      run_idle(50);
      check_obs("t5_wrap", 0, 0, 0);

      // 6: reset during WAIT, result discarded, then normal service
      clear_logs();
      set_op(1'b0, 4'd7, 4'd7, 4'd0);
      cycle(); cycle();
      do_reset();
      for (int i = 0; i < ALU_LAT + 3; i++) cycle();
      chk("t6_no_rsp", obs_c.size(), 0);
      set_op(1'b1, 4'd4, 4'd5, 4'd0);
      set_op(1'b0, 4'd2, 4'd9, 4'd1);
      run_idle(50);
      check_obs("t6_first", 0, 0, 0);
      check_obs("t6_second", 1, 9, 1);

      // Random traffic with random back-pressure
      clear_logs();
      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) cycle();
      rand_mode = 1'b0;
      rr = 1'b1;
      run_idle(100);
      chk("rand_some_rsp", (obs_c.size() > 10), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d", passed, total);
      $fatal(1, "timeout");
   end

endmodule
